// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES-128 decryption sequencer.
package aes_seq_pkg;
    localparam int AES_BLOCK_W        = 128;
    localparam int AES_COL_W          = 32;
    localparam int AES_COLS           = 4;
    localparam int AES_NUM_ROUNDS     = 10;
    localparam int AES_KEY_GEN_CYCLES = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYGEN = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } seq_state_e;
endpackage

// File: rtl/aes_state_assembler.sv
// Collects the four 32-bit datapath columns of one round into a shadow
// register and commits the complete 128-bit round state when the last
// column arrives. Column 0 lives in [127:96], column 3 in [31:0].
module aes_state_assembler
    import aes_seq_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             col_idx,
    input  logic                   col_we,
    input  logic [AES_COL_W-1:0]   col_word,
    input  logic                   commit,
    output logic [AES_BLOCK_W-1:0] state_reg
);

    logic [AES_COLS-1:0][AES_COL_W-1:0] shadow_q, shadow_d;
    logic [AES_BLOCK_W-1:0]             state_q, state_d;

    // Next shadow/state: commit bypasses the shadow for the column arriving now.
    always_comb begin
        shadow_d = shadow_q;
        state_d  = state_q;
        if (col_we) begin
            shadow_d[2'd3 - col_idx] = col_word;
        end
        if (commit) begin
            state_d = {shadow_q[3], shadow_q[2], shadow_q[1], col_word};
        end
    end

    // Register shadow and committed state; cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= '0;
            state_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            state_q  <= state_d;
        end
    end

    assign state_reg = state_q;

endmodule

// File: rtl/aes_dec_sequencer.sv
// Control block for the column-serial AES-128 decryption datapath:
// input handshake, key-schedule wait, round/column sequencing and the
// plaintext output handshake. Optional feature macro AES_SEQ_KEYREUSE_EN
// skips key expansion when the same key is offered again.
// NUM_ROUNDS must be <= 15 (4-bit round counter).
module aes_dec_sequencer
    import aes_seq_pkg::*;
#(
    parameter int NUM_ROUNDS     = AES_NUM_ROUNDS,
    parameter int KEY_GEN_CYCLES = AES_KEY_GEN_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    input  logic [AES_BLOCK_W-1:0] in_key,
    output logic                   key_start,
    output logic [AES_BLOCK_W-1:0] key_out,
    output logic [AES_BLOCK_W-1:0] dp_state,
    output logic [3:0]             dp_round,
    output logic [1:0]             dp_col,
    input  logic [AES_COL_W-1:0]   dp_col_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   busy
);

    localparam int KCW = $clog2(KEY_GEN_CYCLES + 1);

    seq_state_e             state_q, state_d;
    logic [3:0]             round_q, round_d;
    logic [1:0]             col_q, col_d;
    logic [KCW-1:0]         kcnt_q, kcnt_d;
    logic [AES_BLOCK_W-1:0] cipher_q, cipher_d;
    logic [AES_BLOCK_W-1:0] key_q, key_d;
    logic                   in_ready_q, out_valid_q, key_start_q, busy_q;
    logic                   key_start_d;
    logic                   col_we, commit;
    logic [AES_BLOCK_W-1:0] state_reg;
`ifdef AES_SEQ_KEYREUSE_EN
    logic                   key_valid_q, key_valid_d;
`endif

    // Next-state, counter and capture logic for the sequencer FSM.
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        col_d       = col_q;
        kcnt_d      = kcnt_q;
        cipher_d    = cipher_q;
        key_d       = key_q;
        key_start_d = 1'b0;
        col_we      = 1'b0;
        commit      = 1'b0;
`ifdef AES_SEQ_KEYREUSE_EN
        key_valid_d = key_valid_q;
`endif
        case (state_q)
            IDLE: begin
                // in_ready_q is low only during reset, so gate on it too
                if (in_valid && in_ready_q) begin
                    cipher_d = in_data;
                    key_d    = in_key;
                    round_d  = '0;
                    col_d    = '0;
                    kcnt_d   = KCW'(KEY_GEN_CYCLES - 1);
`ifdef AES_SEQ_KEYREUSE_EN
                    if (key_valid_q && (in_key == key_q)) begin
                        state_d = ROUND;
                    end else begin
                        state_d     = KEYGEN;
                        key_start_d = 1'b1;
                    end
`else
                    state_d     = KEYGEN;
                    key_start_d = 1'b1;
`endif
                end
            end
            KEYGEN: begin
                if (kcnt_q == '0) begin
                    state_d = ROUND;
`ifdef AES_SEQ_KEYREUSE_EN
                    key_valid_d = 1'b1;
`endif
                end else begin
                    kcnt_d = kcnt_q - 1'b1;
                end
            end
            ROUND: begin
                col_we = 1'b1;
                col_d  = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    commit = 1'b1;
                    if (round_q == 4'(NUM_ROUNDS)) begin
                        state_d = DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, counters and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            round_q     <= '0;
            col_q       <= '0;
            kcnt_q      <= '0;
            cipher_q    <= '0;
            key_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            key_start_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef AES_SEQ_KEYREUSE_EN
            key_valid_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            col_q       <= col_d;
            kcnt_q      <= kcnt_d;
            cipher_q    <= cipher_d;
            key_q       <= key_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            key_start_q <= key_start_d;
            busy_q      <= (state_d != IDLE);
`ifdef AES_SEQ_KEYREUSE_EN
            key_valid_q <= key_valid_d;
`endif
        end
    end

    aes_state_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_idx   (col_q),
        .col_we    (col_we),
        .col_word  (dp_col_result),
        .commit    (commit),
        .state_reg (state_reg)
    );

    // Round 0 works on the captured ciphertext; later rounds on the committed state.
    assign dp_state  = (round_q == 4'd0) ? cipher_q : state_reg;
    assign dp_round  = round_q;
    assign dp_col    = col_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign key_start = key_start_q;
    assign busy      = busy_q;
    assign key_out   = key_q;
    assign out_data  = state_reg;

endmodule

// File: tb/tb_aes_dec_sequencer.sv
// Self-checking bench for aes_dec_sequencer with a stub column datapath.
module tb_aes_dec_sequencer;
    localparam int N = 10;
    localparam int K = 10;
`ifdef AES_SEQ_KEYREUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [127:0] in_key = '0;
    logic         key_start;
    logic [127:0] key_out;
    logic [127:0] dp_state;
    logic [3:0]   dp_round;
    logic [1:0]   dp_col;
    logic [31:0]  dp_col_result;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int stub_mode = 0;

    always #5 clk = ~clk;

    // Stub datapath: mode 0 tags round/col, mode 1 mixes the addressed column of dp_state.
    function automatic logic [31:0] stub_f(input int mode, input logic [127:0] s,
                                           input logic [3:0] r, input logic [1:0] c);
        logic [31:0] w;
        int ci;
        ci = int'(c);
        if (mode == 0) return {r, c, 26'h0};
        w = s[127 - 32*ci -: 32];
        return {w[26:0], w[31:27]} ^ {r, c, 26'h2a5f31};
    endfunction

    assign dp_col_result = stub_f(stub_mode, dp_state, dp_round, dp_col);

    aes_dec_sequencer #(.NUM_ROUNDS(N), .KEY_GEN_CYCLES(K)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_key(in_key), .key_start(key_start), .key_out(key_out),
        .dp_state(dp_state), .dp_round(dp_round), .dp_col(dp_col),
        .dp_col_result(dp_col_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    // Reference: rounds 0..N, each new state is four stub columns of the previous state.
    function automatic logic [127:0] model_dec(input int mode, input logic [127:0] ct);
        logic [127:0] s, n;
        s = ct;
        n = '0;
        for (int r = 0; r <= N; r++) begin
            for (int c = 0; c < 4; c++) n[127 - 32*c -: 32] = stub_f(mode, s, 4'(r), 2'(c));
            s = n;
        end
        return s;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [127:0] data;
        logic [127:0] key;
        int           mode;
        int           hold;
        bit           early;
        logic [127:0] exp_out;
        int           exp_lat;
        bit           exp_ks;
    } vec_t;

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_key_start"}, key_start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rc"}, {dp_round, dp_col}, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_key_out"}, key_out, 0);
    endtask

    task automatic run_txn(input string tag, input vec_t v);
        int lat, ks_bad, st_bad, hold_bad;
        logic [127:0] held;
        stub_mode = v.mode;
        chk({tag, "_idle_ready"}, in_ready, 1);
        out_ready = v.early;
        in_valid  = 1'b1;
        in_data   = v.data;
        in_key    = v.key;
        tick();
        in_valid = 1'b0;
        in_data  = ~v.data;
        in_key   = ~v.key;
        lat = 0; ks_bad = 0; st_bad = 0;
        chk({tag, "_key_start"}, key_start, v.exp_ks);
        chk({tag, "_key_out"}, key_out, v.key);
        chk({tag, "_busy"}, busy, 1);
        while (!out_valid && lat < 200) begin
            if (dp_round == 4'd0 && dp_state !== v.data) st_bad++;
            tick();
            lat++;
            if (key_start) ks_bad++;
        end
        chk({tag, "_latency"}, lat, v.exp_lat);
        chk({tag, "_ks_once"}, ks_bad, 0);
        chk({tag, "_round0_state"}, st_bad, 0);
        chk({tag, "_out_data"}, out_data, v.exp_out);
        if (!v.early) begin
            held = out_data;
            hold_bad = 0;
            in_valid = 1'b1;
            for (int i = 0; i < v.hold; i++) begin
                tick();
                if (out_data !== held || !out_valid || in_ready || key_start) hold_bad++;
            end
            in_valid = 1'b0;
            chk({tag, "_done_hold"}, hold_bad, 0);
            out_ready = 1'b1;
        end
        tick();
        out_ready = 1'b0;
        chk({tag, "_ready_after"}, in_ready, 1);
        chk({tag, "_valid_drop"}, out_valid, 0);
        chk({tag, "_busy_idle"}, busy, 0);
    endtask

    vec_t tv[6];
    bit           kv;
    logic [127:0] last_key;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Fill latency/key_start expectations from the key-reuse rule.
    task automatic set_key_exp(inout vec_t v);
        bit same;
        same      = REUSE && kv && (v.key == last_key);
        v.exp_lat = same ? 4*(N+1) : K + 4*(N+1);
        v.exp_ks  = !same;
        kv        = 1'b1;
        last_key  = v.key;
    endtask

    initial begin
        logic [127:0] ka, kb;
        vec_t v;
        int guard;
        ka = rnd128();
        kb = rnd128();
        kv = 1'b0;
        last_key = '0;
        for (int i = 0; i < 6; i++) begin
            tv[i].data  = rnd128();
            tv[i].mode  = (i == 0) ? 0 : 1;
            tv[i].key   = (i == 3 || i == 4) ? kb : ka;
            tv[i].hold  = (i == 1) ? 20 : (i == 3 ? 3 : 0);
            tv[i].early = (i == 2 || i == 4);
            tv[i].exp_out = (i == 0) ? {4'hA, 2'd0, 26'h0, 4'hA, 2'd1, 26'h0,
                                        4'hA, 2'd2, 26'h0, 4'hA, 2'd3, 26'h0}
                                     : model_dec(1, tv[i].data);
            set_key_exp(tv[i]);
        end

        // Reset state
        tick();
        tick();
        check_reset_vals("rst");
        rst_n = 1'b1;
        tick();
        chk("rst_release_ready", in_ready, 1);

        for (int i = 0; i < 6; i++) run_txn($sformatf("v%0d", i), tv[i]);

        // Reset in round 5 discards the transaction
        stub_mode = 1;
        in_valid = 1'b1;
        in_data  = rnd128();
        in_key   = ka;
        tick();
        in_valid = 1'b0;
        guard = 0;
        while (dp_round != 4'd5 && guard < 200) begin
            tick();
            guard++;
        end
        chk("mid_reached_r5", dp_round, 5);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_vals("midrst");
        tick();
        chk("midrst_ready", in_ready, 1);
        kv = 1'b0;
        last_key = '0;
        v.data = rnd128();
        v.key = ka;
        v.mode = 1;
        v.hold = 2;
        v.early = 1'b0;
        v.exp_out = model_dec(1, v.data);
        set_key_exp(v);
        run_txn("post_rst", v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule
